// File: rtl/fdd_motor_ctl.sv
// ---------------------------------------------------------------------------
// fdd_motor_ctl : floppy spindle motor sequencer with 100 Hz timebase and
//                 emulated index pulse.                       Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fdd_motor_ctl #(
  parameter int MCLKFREQ     = 24000000,
  parameter int SPINUP_TICKS = 50,
  parameter int IDLE_TICKS   = 300,
  parameter int REV_TICKS    = 20,
  parameter int INDEX_CLKS   = MCLKFREQ / 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       motor_req,
  input  logic       activity,
  output logic       tick100,
  output logic       motor,
  output logic       ready,
  output logic       index,
  output logic [1:0] state
);

  localparam logic [17:0] C_PRESC_RELOAD = 18'(MCLKFREQ / 100 - 1);
  localparam logic [8:0]  C_SPINUP       = 9'(SPINUP_TICKS);
  localparam logic [8:0]  C_IDLE         = 9'(IDLE_TICKS);
  localparam int          REV_W          = (REV_TICKS > 1) ? $clog2(REV_TICKS) : 1;
  localparam logic [REV_W-1:0] C_REV_LAST = REV_W'(REV_TICKS - 1);
  localparam int          IDX_W          = $clog2(INDEX_CLKS + 1);
  localparam logic [IDX_W-1:0] C_INDEX   = IDX_W'(INDEX_CLKS);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_SPINUP  = 2'd1,
    ST_READY   = 2'd2,
    ST_RUNDOWN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [17:0]      presc_q, presc_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             w_tick;
  logic             w_ready;
  logic             w_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= C_PRESC_RELOAD;
      state_q <= ST_OFF;
      cnt_q   <= '0;
      rev_q   <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rev_q   <= rev_d;
      idx_q   <= idx_d;
    end
  end

  assign w_tick  = (presc_q == 18'd0);
  assign w_ready = (state_q == ST_READY) || (state_q == ST_RUNDOWN);
  assign presc_d = w_tick ? C_PRESC_RELOAD : presc_q - 18'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (motor_req) begin
          state_d = ST_SPINUP;
          cnt_d   = C_SPINUP;
        end
      end
      ST_SPINUP: begin
        if (!motor_req) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (w_tick) begin
          if (cnt_q == 9'd1) state_d = ST_READY;
          else               cnt_d   = cnt_q - 9'd1;
        end
      end
      ST_READY: begin
        if (!motor_req) begin
          state_d = ST_RUNDOWN;
          cnt_d   = C_IDLE;
        end
      end
      ST_RUNDOWN: begin
        // motor_req beats activity beats tick: a coincident tick never decrements
        if (motor_req) begin
          state_d = ST_READY;
        end else if (activity) begin
          cnt_d = C_IDLE;
        end else if (w_tick) begin
          if (cnt_q == 9'd1) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 9'd1;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    rev_d  = rev_q;
    w_wrap = 1'b0;
    if (state_q == ST_OFF) begin
      rev_d = '0;
    end else if (w_tick) begin
      if (rev_q == C_REV_LAST) begin
        rev_d  = '0;
        w_wrap = 1'b1;
      end else begin
        rev_d = rev_q + REV_W'(1);
      end
    end
  end

  // A started pulse runs to completion regardless of later FSM state.
  always_comb begin
    idx_d = idx_q;
    if (w_wrap && w_ready)     idx_d = C_INDEX;
    else if (idx_q != '0)      idx_d = idx_q - IDX_W'(1);
  end

  assign tick100 = w_tick;
  assign motor   = (state_q != ST_OFF);
  assign ready   = w_ready;
  assign index   = (idx_q != '0);
  assign state   = state_q;

endmodule

`default_nettype wire

// File: doc/fdd_motor_ctl.md
FDD_MOTOR_CTL -- requirements
Module: fdd_motor_ctl

Interface
REQ-001 Parameter MCLKFREQ, default 24000000, is the clk frequency in Hz.
REQ-002 Parameter SPINUP_TICKS, default 50, is the spin-up time in 10 ms ticks.
REQ-003 Parameter IDLE_TICKS, default 300, is the run-down timeout in 10 ms ticks.
REQ-004 Parameter REV_TICKS, default 20, is one revolution (300 RPM) in 10 ms ticks.
REQ-005 Parameter INDEX_CLKS, default MCLKFREQ/250, is the index pulse width in clk cycles (4 ms).
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 motor_req  in  1  level; motor-on bit from the controller register.
REQ-009 activity  in  1  one-cycle strobe on any disk access; restarts the run-down timeout.
REQ-010 tick100  out  1  one-cycle 100 Hz strobe, exported for the downstream timeout timer.
REQ-011 motor  out  1  spindle motor enable.
REQ-012 ready  out  1  drive ready (at speed).
REQ-013 index  out  1  emulated index pulse, active high.
REQ-014 state  out  2  FSM state: 0 OFF, 1 SPINUP, 2 READY, 3 RUNDOWN.

Function
REQ-015 The prescaler SHALL be an 18-bit down-counter reloading MCLKFREQ/100-1 when it reaches 0; tick100 SHALL be high exactly in the cycle it is 0.
REQ-016 The FSM SHALL have states OFF, SPINUP, READY, RUNDOWN; motor SHALL be 1 in SPINUP, READY and RUNDOWN; ready SHALL be 1 only in READY and RUNDOWN.
REQ-017 OFF: motor_req=1 SHALL go to SPINUP and load the state counter with SPINUP_TICKS.
REQ-018 SPINUP: motor_req=0 SHALL go to OFF next cycle; otherwise on tick100 with counter==1 SHALL go to READY, else on tick100 decrement.
REQ-019 READY: motor_req=0 SHALL go to RUNDOWN and load the counter with IDLE_TICKS; activity SHALL be ignored.
REQ-020 RUNDOWN: motor_req=1 SHALL return to READY (no spin-up); activity SHALL reload IDLE_TICKS; otherwise on tick100 with counter==1 SHALL go to OFF, else decrement.
REQ-021 Priority in RUNDOWN: motor_req over activity over tick100 (same-cycle activity and tick100 reloads, no decrement).
REQ-022 The state counter SHALL be 9 bits; parameters are limited to 1..511.
REQ-023 The revolution counter SHALL count tick100 modulo REV_TICKS while motor=1, and SHALL be held at 0 in OFF.
REQ-024 When the revolution counter wraps from REV_TICKS-1 to 0 while ready=1, index SHALL rise next cycle and stay high for exactly INDEX_CLKS cycles.
REQ-025 An index pulse in progress SHALL complete even if the FSM leaves READY/RUNDOWN, except on reset.
REQ-026 Transition to OFF SHALL occur on the cycle after the expiring tick100; motor and ready SHALL fall together.

Reset
REQ-027 On reset=1 the block SHALL enter OFF; state counter, revolution counter and index width counter SHALL be 0; prescaler SHALL load MCLKFREQ/100-1.
REQ-028 Reset SHALL override every other input in the same cycle; outputs after reset: tick100=0, motor=0, ready=0, index=0, state=0.
REQ-029 Reset asserted mid-pulse or mid-spin-up SHALL abort it with no residual pulse.

Verification (MCLKFREQ=1000, SPINUP_TICKS=3, IDLE_TICKS=4, REV_TICKS=5, INDEX_CLKS=2: tick100 every 10 clk)
REQ-030 Release reset, idle -> tick100 first high 10 cycles after reset release, period 10; motor=ready=index=0.
REQ-031 motor_req=1 from OFF -> motor=1 next cycle, state=1; ready=1 (state=2) on the cycle after the 3rd tick100.
REQ-032 Hold READY -> index high for 2 cycles after every 5th tick100 counted from spin-up start, period 50 cycles.
REQ-033 motor_req=0 in READY, no activity -> state=3 immediately, OFF after 4th tick100; activity pulse before 4th tick100 -> 4 more ticks required.
REQ-034 motor_req dropped during SPINUP -> state=0 next cycle, ready never asserted; reassert in RUNDOWN -> state=2 next cycle, motor never drops.
REQ-035 reset during an index pulse -> index=0 and state=0 on the next cycle.
